// File: rtl/jitter_delay_line.sv
// Multi-channel shift-register delay line with programmable, LFSR-jittered tap
// and a bounded run controller with heartbeat and output-activity counter.
module jitter_delay_line #(
  parameter int          WIDTH       = 8,
  parameter int          DEPTH       = 64,
  parameter int          JITTER_BITS = 2,
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int          HB_PERIOD   = 1000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [31:0]              run_len,
  input  logic [$clog2(DEPTH)-1:0] delay_sel,
  input  logic                     jitter_en,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     busy,
  output logic                     done,
  output logic                     hb,
  output logic [31:0]              toggle_cnt
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [15:0] MASK     = 16'hB400;
  localparam logic [AW:0] MAXTAP   = (AW+1)'(DEPTH - 1);
  localparam logic [31:0] HB_LAST  = 32'(HB_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] sr [DEPTH];
  logic [15:0]      lfsr;
  logic [31:0]      cyc_cnt;
  logic [31:0]      run_len_q;
  logic [31:0]      hb_cnt;

  logic             accept;
  logic             fin;
  logic             in_run;
  logic [AW:0]      jit;
  logic [AW:0]      tap_sum;
  logic [AW-1:0]    tap;
  logic [WIDTH-1:0] tap_val;

  assign in_run = (state == RUN);
  assign busy   = in_run;
  assign done   = (state == DONE);

  // abort outranks both start and completion
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    fin      = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (start) begin
          accept   = 1'b1;
          state_nx = (run_len == 32'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        fin = (cyc_cnt == run_len_q - 32'd1);
        if (abort) begin
          state_nx = IDLE;
        end else if (fin) begin
          state_nx = DONE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // sum is one bit wider than the index so a large jitter cannot wrap
  always_comb begin
    jit = '0;
    if (jitter_en) begin
      jit = (AW+1)'(lfsr[JITTER_BITS-1:0]);
    end
    tap_sum = {1'b0, delay_sel} + jit;
    tap     = (tap_sum > MAXTAP) ? MAXTAP[AW-1:0] : tap_sum[AW-1:0];
    tap_val = sr[tap];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        sr[k] <= '0;
      end
    end else if (in_run) begin
      sr[0] <= din;
      for (int k = 1; k < DEPTH; k++) begin
        sr[k] <= sr[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= SEED_EFF;
    end else if (in_run) begin
      lfsr <= lfsr[0] ? ((lfsr >> 1) ^ MASK) : (lfsr >> 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      toggle_cnt <= '0;
    end else if (accept) begin
      toggle_cnt <= '0;
    end else if (in_run) begin
      dout <= tap_val;
      if ((tap_val != dout) && (toggle_cnt != 32'hFFFF_FFFF)) begin
        toggle_cnt <= toggle_cnt + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt   <= '0;
      run_len_q <= '0;
      hb_cnt    <= '0;
      hb        <= 1'b0;
    end else begin
      hb <= in_run && (hb_cnt == HB_LAST);
      if (accept) begin
        cyc_cnt   <= '0;
        run_len_q <= run_len;
        hb_cnt    <= '0;
      end else if (in_run) begin
        cyc_cnt <= cyc_cnt + 32'd1;
        hb_cnt  <= (hb_cnt == HB_LAST) ? 32'd0 : hb_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_jitter_delay_line.sv
// Scoreboard bench for jitter_delay_line: fixed-latency, jittered-tap,
// heartbeat, abort and mid-run reset scenarios.
module tb_jitter_delay_line;

  localparam int D = 64;

  logic        clk = 1'b0;
  logic        rst, start, abort, jitter_en;
  logic [31:0] run_len;
  logic [5:0]  delay_sel;
  logic [7:0]  din;
  logic [7:0]  dout, dout1;
  logic        busy, done, hb, busy1, done1, hb1;
  logic [31:0] tc, tc1;

  int vecs = 0;
  int miscompares = 0;

  logic [7:0]  msr [D];
  logic [15:0] mlfsr;
  logic [7:0]  mdout;

  always #5 clk = ~clk;

  jitter_delay_line dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .run_len(run_len), .delay_sel(delay_sel),
    .jitter_en(jitter_en), .din(din), .dout(dout),
    .busy(busy), .done(done), .hb(hb), .toggle_cnt(tc)
  );

  jitter_delay_line #(.HB_PERIOD(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .run_len(run_len), .delay_sel(delay_sel),
    .jitter_en(jitter_en), .din(din), .dout(dout1),
    .busy(busy1), .done(done1), .hb(hb1), .toggle_cnt(tc1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    logic [15:0] r;
    r = {1'b0, l[15:1]};
    if (l[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  task automatic do_reset;
    rst = 1'b1; start = 1'b0; abort = 1'b0; din = '0;
    tick; tick;
    rst = 1'b0;
    for (int k = 0; k < D; k++) msr[k] = '0;
    mlfsr = 16'hACE1;
    mdout = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    run_len = 32'd0; delay_sel = '0; jitter_en = 1'b0; din = '0;
    tick; tick;
    vecs++;
    if (dout !== 8'h00) begin
      miscompares++; $display("FAIL reset_dout got %h want 00", dout);
    end
    vecs++;
    if ({busy, done, hb} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_flags busy/done/hb got %b want 000", {busy, done, hb});
    end
    vecs++;
    if (tc !== 32'd0) begin
      miscompares++; $display("FAIL reset_toggle got %0d want 0", tc);
    end
    do_reset;
  endtask

  task automatic test_basic;
    logic [7:0] q[$];
    logic [7:0] exp;
    q = '{8'h00, 8'h00, 8'h00, 8'h00};
    delay_sel = 6'd3; jitter_en = 1'b0; run_len = 32'd20; din = '0;
    start = 1'b1; tick; start = 1'b0;
    vecs++;
    if (busy !== 1'b1 || hb1 !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_first busy/hb1 got %b%b want 10", busy, hb1);
    end
    for (int n = 1; n <= 20; n++) begin
      din = (n == 2) ? 8'h01 : 8'h00;
      q.push_back(din);
      tick;
      exp = q.pop_front();
      vecs++;
      if (dout !== exp) begin
        miscompares++;
        $display("FAIL basic_dout edge %0d got %h want %h", n, dout, exp);
      end
      vecs++;
      if (busy !== (n < 20) || done !== (n == 20)) begin
        miscompares++;
        $display("FAIL basic_state edge %0d busy/done got %b%b", n, busy, done);
      end
      if (n < 20) begin
        vecs++;
        if (hb1 !== 1'b1) begin
          miscompares++;
          $display("FAIL hb_period1 edge %0d got %b want 1", n, hb1);
        end
      end
    end
    din = '0;
    vecs++;
    if (tc !== 32'd2) begin
      miscompares++; $display("FAIL basic_toggle got %0d want 2", tc);
    end
  endtask

  task automatic test_zero_len;
    run_len = 32'd0;
    start = 1'b1; tick; start = 1'b0;
    vecs++;
    if (done !== 1'b1 || busy !== 1'b0 || tc !== 32'd0) begin
      miscompares++;
      $display("FAIL zero_len got done=%b busy=%b tc=%0d want 1 0 0",
               done, busy, tc);
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      vecs++;
      if (busy !== 1'b0 || done !== 1'b1) begin
        miscompares++;
        $display("FAIL zero_len_hold busy/done got %b%b want 01", busy, done);
      end
    end
  endtask

  task automatic test_tap(input int dsel, input logic jen, input int len);
    logic [7:0] q[$];
    logic [7:0] exp, got;
    int t, mtc;
    mtc = 0;
    delay_sel = dsel[5:0]; jitter_en = jen; run_len = len;
    start = 1'b1; tick; start = 1'b0;
    for (int n = 1; n <= len; n++) begin
      din = 8'($urandom);
      t = dsel + (jen ? int'(mlfsr[1:0]) : 0);
      if (t > D - 1) t = D - 1;
      exp = msr[t];
      q.push_back(exp);
      if (exp != mdout) mtc++;
      mdout = exp;
      for (int k = D - 1; k > 0; k--) msr[k] = msr[k-1];
      msr[0] = din;
      mlfsr = lfsr_step(mlfsr);
      tick;
      got = q.pop_front();
      vecs++;
      if (dout !== got) begin
        miscompares++;
        $display("FAIL tap_dout sel=%0d jit=%0b edge %0d got %h want %h",
                 dsel, jen, n, dout, got);
      end
    end
    vecs++;
    if (tc !== 32'(mtc) || done !== 1'b1) begin
      miscompares++;
      $display("FAIL tap_end sel=%0d tc=%0d want %0d done=%b",
               dsel, tc, mtc, done);
    end
  endtask

  task automatic test_heartbeat;
    int hq[$];
    int p;
    hq = '{1001, 2001, 3001};
    run_len = 32'd3500; delay_sel = 6'd0; jitter_en = 1'b0;
    start = 1'b1; tick; start = 1'b0;
    for (int c = 1; c <= 3500; c++) begin
      din = 8'(c);
      if (hb === 1'b1) begin
        vecs++;
        if (hq.size() == 0) begin
          miscompares++;
          $display("FAIL hb_extra pulse in cycle %0d want none", c);
        end else begin
          p = hq.pop_front();
          if (c != p) begin
            miscompares++;
            $display("FAIL hb_cycle got %0d want %0d", c, p);
          end
        end
      end
      tick;
    end
    vecs++;
    if (hq.size() != 0 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL hb_missing left %0d want 0 done=%b", hq.size(), done);
    end
  endtask

  task automatic test_abort;
    logic [7:0] pat [7];
    logic [7:0] q[$];
    logic [7:0] exp;
    int cnt;
    pat = '{8'h01, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h03};
    q = '{8'h00};
    do_reset;
    delay_sel = 6'd0; jitter_en = 1'b0; run_len = 32'd50;
    start = 1'b1; tick; start = 1'b0;
    for (int n = 1; n <= 7; n++) begin
      din = pat[n-1];
      abort = (n == 7);
      start = (n == 7);
      q.push_back(din);
      tick;
      exp = q.pop_front();
      vecs++;
      if (dout !== exp) begin
        miscompares++;
        $display("FAIL abort_dout edge %0d got %h want %h", n, dout, exp);
      end
    end
    abort = 1'b0; start = 1'b0;
    vecs++;
    if (busy !== 1'b0 || done !== 1'b0 || tc !== 32'd3) begin
      miscompares++;
      $display("FAIL abort_state busy=%b done=%b tc=%0d want 0 0 3",
               busy, done, tc);
    end
    tick; tick;
    run_len = 32'd5;
    start = 1'b1; tick; start = 1'b0;
    vecs++;
    if (tc !== 32'd0) begin
      miscompares++; $display("FAIL restart_toggle got %0d want 0", tc);
    end
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy === 1'b1) cnt++;
      tick;
    end
    vecs++;
    if (cnt != 5 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_len busy cycles %0d want 5 done=%b", cnt, done);
    end
  endtask

  task automatic test_rst_midrun;
    int cnt;
    delay_sel = 6'd0; jitter_en = 1'b1; run_len = 32'd50;
    start = 1'b1; tick; start = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      din = 8'($urandom) | 8'h80;
      rst = (n == 10);
      tick;
    end
    rst = 1'b0;
    vecs++;
    if (dout !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid dout=%h busy=%b done=%b want 00 0 0",
               dout, busy, done);
    end
    vecs++;
    if (tc !== 32'd0 || hb !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_cnt tc=%0d hb=%b want 0 0", tc, hb);
    end
    start = 1'b1; tick; start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      if (busy === 1'b1) cnt++;
      tick;
    end
    vecs++;
    if (cnt != 50 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_rerun busy cycles %0d want 50 done=%b", cnt, done);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_zero_len;
    do_reset;
    test_tap(63, 1'b1, 200);
    test_tap(61, 1'b1, 150);
    test_tap(0, 1'b1, 80);
    test_tap(5, 1'b0, 40);
    test_heartbeat;
    test_abort;
    test_rst_midrun;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule

// File: doc/jitter_delay_line.md
# jitter_delay_line

Clocked, parametrised successor to the team's cascaded random-delay stress chain. It provides WIDTH parallel channels through a DEPTH-stage shift-register delay line with a programmable tap and optional LFSR-driven per-cycle tap jitter. A run controller bounds the run length, emits a heartbeat and counts output activity. It sits between the stimulus generator and the DUT in simulation-throughput and waveform-dump benchmarks.

## Interface
- WIDTH, 8, number of parallel channels.
- DEPTH, 64, number of delay stages; ≥2, power of two.
- JITTER_BITS, 2, LFSR bits added to the tap; jitter range 0..2^JITTER_BITS-1.
- SEED, 16'hACE1, LFSR reset value; 0 is replaced by 16'h0001.
- HB_PERIOD, 1000, RUN cycles per heartbeat pulse; ≥1.
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse that starts a run.
- abort  in  1  ends the run immediately.
- run_len  in  32  RUN cycles per run, sampled on start.
- delay_sel  in  log2(DEPTH)  base tap index.
- jitter_en  in  1  adds LFSR jitter to the tap.
- din  in  WIDTH  channel inputs.
- dout  out  WIDTH  delayed channel outputs, registered.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- hb  out  1  one-cycle heartbeat pulse.
- toggle_cnt  out  32  saturating count of dout change cycles.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start when run_len≠0.
  - IDLE -> DONE on start when run_len=0.
  - RUN -> DONE when cyc_cnt = run_len_q-1.
  - RUN -> IDLE on abort; done stays low.
  - DONE -> RUN on start; same run_len=0 rule applies.
  - DONE -> IDLE on abort.
  - start in RUN is ignored.
  - abort has priority over start and over completion in the same cycle.
- Shift register sr[0..DEPTH-1]: in RUN only, sr[0]<=din and sr[k]<=sr[k-1]; it holds in IDLE and DONE.
  - sr contents are NOT cleared on start, so a restart replays residual data.
- Tap computation:
  - jit = jitter_en ? lfsr[JITTER_BITS-1:0] : 0.
  - tap = min(delay_sel + jit, DEPTH-1), computed at log2(DEPTH)+1 bits so the sum cannot wrap.
- dout: in RUN, dout<=sr[tap] using the pre-shift sr value; dout holds outside RUN.
- LFSR: 16-bit Galois, mask 16'hB400, shifts right each RUN cycle; holds otherwise.
- Counters:
  - cyc_cnt (32b) clears on the start that enters RUN and increments each RUN cycle.
  - run_len_q latches run_len on start.
  - hb_cnt counts 0..HB_PERIOD-1 in RUN and wraps to 0; hb=1 in the cycle after hb_cnt=HB_PERIOD-1.
  - hb_cnt clears on start.
- toggle_cnt:
  - Increments in the cycle dout is updated with a value ≠ the current dout.
  - Saturates at 32'hFFFF_FFFF.
  - Clears on any accepted start.

## Timing
- Reset values: sr all 0, dout 0, busy 0, done 0, hb 0, toggle_cnt 0, lfsr SEED (or 1), state IDLE, all counters 0.
- start sampled at edge E makes busy=1 after E; the first RUN cycle is the one following E.
- Latency with constant tap t, run in steady state: din at RUN edge n appears on dout after edge n+t+1.
- With run_len=L, busy is high for exactly L cycles and done rises on the cycle after the last RUN cycle.
- done falls on the edge that accepts start or abort.
- tap may change every cycle; glitches on dout are intended behaviour.
- Boundary conditions:
  - delay_sel=DEPTH-1 with jitter: tap clamps to DEPTH-1.
  - HB_PERIOD=1: hb stays high through RUN from the second RUN cycle on.
  - rst mid-run returns all outputs to reset values on the next edge.

## Test plan
- Reset, then start with run_len=20, delay_sel=3, jitter_en=0, single-cycle din pulse on bit0 in RUN cycle 2 -> dout[0] pulses 4 cycles later; busy high for 20 cycles; done=1 afterwards; toggle_cnt=2.
- run_len=0 start -> done=1 next cycle; busy never asserts; toggle_cnt=0.
- delay_sel=DEPTH-1, jitter_en=1, din toggling every cycle -> latency is always DEPTH (clamped); no X on dout; lfsr sequence matches the reference model with seed ACE1.
- HB_PERIOD=1000, run_len=3500 -> exactly 3 hb pulses, in RUN cycles 1001, 2001 and 3001.
- abort in RUN cycle 7 coincident with start -> IDLE; done=0; toggle_cnt retained; a following start clears toggle_cnt and restarts cyc_cnt from 0.
- rst asserted in RUN cycle 10 of 50 -> next edge gives dout=0, busy=0, done=0; a later start runs a full 50 cycles.
